// File: rtl/mcsb_pkg.sv
// Shared types and helpers for the multi-channel tracking scoreboard.
package mcsb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        DONE
    } state_e;

    localparam int MODE_FIFO = 0;
    localparam int MODE_LIFO = 1;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mcsb_channel.sv
// One scoreboard channel: shadow occupancy, tracked-element FSM and
// per-cycle environment-violation detection.
module mcsb_channel
    import mcsb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int MODE  = MODE_FIFO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] data_out_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             done_o,
    output logic             ok_o,
    output logic             viol_o
);

    localparam int OW = occ_width(DEPTH);
    localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
    localparam logic [OW-1:0] ONE     = OW'(1);

    state_e           state_q, state_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [OW-1:0]    ahead_q, ahead_d;
    logic [WIDTH-1:0] trk_q, trk_d;
    logic             match_q, match_d;
    logic             is_full, is_empty;

    assign is_full  = (occ_q == OCC_MAX);
    assign is_empty = (occ_q == '0);

    // Illegal push/pop are absorbed here, so occ saturates instead of wrapping.
    always_comb begin
        occ_d = occ_q;
        if (push_i && !pop_i && !is_full) begin
            occ_d = occ_q + ONE;
        end else if (pop_i && !push_i && !is_empty) begin
            occ_d = occ_q - ONE;
        end
    end

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ahead_d = ahead_q;
        trk_d   = trk_q;
        match_d = match_q;
        case (state_q)
            IDLE: begin
                if (start_i && push_i) begin
                    trk_d   = data_in_i;
                    state_d = TRACK;
                    if (MODE == MODE_FIFO) begin
                        ahead_d = (pop_i && !is_empty) ? occ_q - ONE : occ_q;
                    end else begin
                        ahead_d = '0;
                    end
                end
            end
            TRACK: begin
                if (pop_i && ahead_q == '0) begin
                    match_d = (data_out_i == trk_q);
                    state_d = DONE;
                end else if (MODE == MODE_LIFO) begin
                    if (push_i && !pop_i && ahead_q != OCC_MAX) begin
                        ahead_d = ahead_q + ONE;
                    end else if (pop_i && !push_i) begin
                        ahead_d = ahead_q - ONE;
                    end
                end else if (pop_i) begin
                    ahead_d = ahead_q - ONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            ahead_q <= '0;
            trk_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            ahead_q <= ahead_d;
            trk_q   <= trk_d;
            match_q <= match_d;
        end
    end

    assign full_o  = is_full;
    assign empty_o = is_empty;
    assign done_o  = (state_q == DONE);
    assign ok_o    = !done_o || match_q;
    assign viol_o  = (push_i && is_full) || (pop_i && is_empty)
                   || ((MODE == MODE_LIFO) && push_i && pop_i);

endmodule

// File: rtl/multi_channel_scoreboard.sv
// NCH independent tracking channels with a global safety property and a
// sticky environment-violation flag.
module multi_channel_scoreboard
    import mcsb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NCH   = 2,
    parameter int MODE  = MODE_FIFO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NCH-1:0]       push,
    input  logic [NCH-1:0]       pop,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [NCH*WIDTH-1:0] data_out,
    output logic [NCH-1:0]       full,
    output logic [NCH-1:0]       empty,
    output logic [NCH-1:0]       chk_done,
    output logic                 prop_signal,
    output logic                 env_violation
);

    logic [NCH-1:0] ok;
    logic [NCH-1:0] viol;
    logic           env_q, env_d;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        mcsb_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .MODE  (MODE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start_i    (start),
            .push_i     (push[c]),
            .pop_i      (pop[c]),
            .data_in_i  (data_in[c*WIDTH +: WIDTH]),
            .data_out_i (data_out[c*WIDTH +: WIDTH]),
            .full_o     (full[c]),
            .empty_o    (empty[c]),
            .done_o     (chk_done[c]),
            .ok_o       (ok[c]),
            .viol_o     (viol[c])
        );
    end

    assign env_d = env_q || (|viol);

    always_ff @(posedge clk) begin
        if (rst) begin
            env_q <= 1'b0;
        end else begin
            env_q <= env_d;
        end
    end

    assign prop_signal   = &ok;
    assign env_violation = env_q;

endmodule

// File: doc/multi_channel_scoreboard.md
# multi_channel_scoreboard

Parametrised successor to the single-channel tracking scoreboard used in the FIFO formal harnesses. Checks NCH independent FIFO-or-LIFO channels of a DUT in parallel. Each channel tracks one symbolically chosen element from push to pop, checks it leaves the DUT at the correct position with the correct value, and reports a per-channel and global safety property. Also flags environment-constraint violations (push on full, pop on empty) that the harness top-level previously asserted inline. Sits beside the DUT in a formal/simulation top, driven by the same push/pop/data nets.

## Interface
- WIDTH, 8, data word width
- DEPTH, 4, DUT capacity per channel (≥1)
- NCH, 2, number of independent channels (≥1)
- MODE, 0, ordering checked: 0 = FIFO, 1 = LIFO
- clk  in  1  single clock, rising edge; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  arm tracking; an idle channel captures on the first cycle with start & push[c]
- push  in  NCH  per-channel push strobe
- pop  in  NCH  per-channel pop strobe
- data_in  in  NCH*WIDTH  channel c at [c*WIDTH +: WIDTH]
- data_out  in  NCH*WIDTH  DUT output word per channel, valid in the pop cycle
- full  out  NCH  scoreboard shadow occupancy == DEPTH
- empty  out  NCH  shadow occupancy == 0
- chk_done  out  NCH  channel has compared its tracked element
- prop_signal  out  1  AND over channels of (~chk_done[c] | match[c]); must stay 1
- env_violation  out  1  sticky; set on any illegal push/pop

## Operation
- Per channel: shadow occupancy occ (0..DEPTH, width $clog2(DEPTH+1)); push increments, pop decrements, push&pop leaves it unchanged.
- Per-channel FSM: IDLE -> TRACK -> DONE.
  - IDLE: if start & push[c], capture data_in[c] into trk and go to TRACK. In FIFO mode, ahead = occ − pop[c]. In LIFO mode, ahead = 0.
  - TRACK, FIFO mode: pop with ahead > 0 decrements ahead. Pushes are ignored.
  - TRACK, LIFO mode: push increments ahead; pop with ahead > 0 decrements it.
  - TRACK, either mode: pop with ahead == 0 compares data_out[c] with trk, stores match, and goes to DONE.
  - DONE: terminal until rst; match is frozen.
- Capture and the compare pop may not occur in the same cycle: a channel captures in IDLE and compares at the earliest one cycle later.
- Illegal events set env_violation, which stays set until rst:
  - push[c] while occ == DEPTH, even with a simultaneous pop;
  - pop[c] while occ == 0, even with a simultaneous push;
  - MODE = 1 with push[c] & pop[c] in the same cycle.
- occ saturates at 0 and DEPTH on illegal events; it does not wrap.
- start has no effect on channels outside IDLE. Channels arm independently.

## Timing
- Reset values: every FSM in IDLE, occ = 0, ahead = 0, trk = 0, match = 0, env_violation = 0.
- Output values at reset: full = 0, empty = 1, chk_done = 0, prop_signal = 1.
- All outputs are combinational from registers only: no input-to-output path.
- Compare uses data_out sampled in the pop cycle. chk_done and prop_signal reflect the result from the next cycle.
- rst mid-tracking returns every channel to IDLE next cycle and discards trk.
- ahead width equals the occ width. LIFO ahead never exceeds DEPTH−1 under legal stimulus.

## Structure
- Package mcsb_pkg holds: state enum {IDLE, TRACK, DONE}, MODE_FIFO/MODE_LIFO localparams, and a function for the occupancy width.
- Sub-module mcsb_channel implements one channel (occ, FSM, ahead, trk, match, per-channel violation).
- The top instantiates NCH copies via generate. It also holds the prop_signal reduction and the sticky env_violation register.

## Test plan
- FIFO, NCH=2, DEPTH=4: push 0x11, 0x22 on ch0; start with push 0x33; pop three times returning 0x11, 0x22, 0x33 -> chk_done[0]=1, prop_signal=1.
- Same sequence with the third pop returning 0x34 -> prop_signal=0 from the cycle after that pop.
- LIFO: push 0xA0 with start; push 0xB0; pop returns 0xB0; pop returns 0xA0 -> match, prop_signal=1.
- Push on ch1 while occ=4 (with and without a simultaneous pop) -> env_violation=1 next cycle and stays set; occ[1] stays 4.
- Independence: ch0 DONE with a mismatch while ch1 is in TRACK -> prop_signal=0. Assert rst -> next cycle prop_signal=1, empty=2'b11, env_violation=0.
- FIFO simultaneous push&pop at occ=2 while in TRACK with ahead=1 -> ahead becomes 0 and occ stays 2; the next pop performs the compare.
